// File: rtl/rf_access_ctrl_if.sv
// Requester-side bundle for one port of rf_access_ctrl: a request channel
// carrying read/write commands and a response channel returning read data.
interface rf_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// Round-robin two-port front end for the 16x32 register file: serialises
// accepted requests into single write or read cycles and returns read data.
module rf_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_access_ctrl_if.slave   port_a,
    rf_access_ctrl_if.slave   port_b,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data
);

    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic              grant_a, grant_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Owner and last_grant encode A as 0 and B as 1; a tie goes to whichever
    // port did not win last time.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (port_a.req_valid && port_b.req_valid) begin
                grant_a = last_grant_q;
                grant_b = !last_grant_q;
            end else begin
                grant_a = port_a.req_valid;
                grant_b = port_b.req_valid;
            end
        end
    end

    assign sel_we    = grant_b ? port_b.req_we    : port_a.req_we;
    assign sel_addr  = grant_b ? port_b.req_addr  : port_a.req_addr;
    assign sel_wdata = grant_b ? port_b.req_wdata : port_a.req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_a || grant_b) begin
                owner_q      <= grant_b;
                last_grant_q <= grant_b;
                addr_q       <= sel_addr;
                if (sel_we) begin
                    wdata_q <= sel_wdata;
                end
            end
        end
    end

    // Everything visible to the requesters and the register file is masked
    // during reset so an in-flight write or read response is simply dropped.
    always_comb begin
        state_d          = state_q;
        rf_read_en       = 1'b0;
        rf_write_en      = 1'b0;
        port_a.req_ready = 1'b0;
        port_b.req_ready = 1'b0;
        port_a.rsp_valid = 1'b0;
        port_b.rsp_valid = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    port_a.req_ready = grant_a;
                    port_b.req_ready = grant_b;
                    if (grant_a || grant_b) begin
                        state_d = sel_we ? WR : RD;
                    end
                end
                WR: begin
                    rf_write_en = 1'b1;
                    state_d     = IDLE;
                end
                RD: begin
                    rf_read_en = 1'b1;
                    state_d    = RSP;
                end
                RSP: begin
                    port_a.rsp_valid = !owner_q;
                    port_b.rsp_valid = owner_q;
                    if (owner_q ? port_b.rsp_ready : port_a.rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rf_addr          = rst ? '0 : addr_q;
    assign rf_write_data    = rst ? '0 : wdata_q;
    assign port_a.rsp_rdata = rf_read_data;
    assign port_b.rsp_rdata = rf_read_data;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Randomised bench for rf_access_ctrl: queued requests per port, a behavioural
// register file, and a transaction-level model predicting every cycle.
module tb_rf_access_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    rf_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a_if ();
    rf_access_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b_if ();

    logic              rf_read_en, rf_write_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_write_data, rf_read_data;

    rf_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .port_a        (a_if),
        .port_b        (b_if),
        .rf_read_en    (rf_read_en),
        .rf_write_en   (rf_write_en),
        .rf_addr       (rf_addr),
        .rf_write_data (rf_write_data),
        .rf_read_data  (rf_read_data)
    );

    // Register file with a registered read port.
    logic [DATA_W-1:0] rf_mem [16];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 32'(i) * 32'h0101_0101;
        end else begin
            if (rf_write_en) rf_mem[rf_addr] <= rf_write_data;
            if (rf_read_en)  rf_read_data <= rf_mem[rf_addr];
        end
    end

    logic [1:0]        drv_valid = '0, drv_we = '0, drv_rsp_ready = '0;
    logic [ADDR_W-1:0] drv_addr [2] = '{'0, '0};
    logic [DATA_W-1:0] drv_wdata [2] = '{'0, '0};
    logic [1:0]        dut_ready, dut_rsp_valid;
    logic [DATA_W-1:0] dut_rdata [2];
    logic [1:0]        hs_seen = '0;
    int                req_pct [2] = '{100, 100};
    int                rdy_pct [2] = '{100, 100};
    req_t              qa[$], qb[$];

    assign a_if.req_valid = drv_valid[0];
    assign a_if.req_we    = drv_we[0];
    assign a_if.req_addr  = drv_addr[0];
    assign a_if.req_wdata = drv_wdata[0];
    assign a_if.rsp_ready = drv_rsp_ready[0];
    assign b_if.req_valid = drv_valid[1];
    assign b_if.req_we    = drv_we[1];
    assign b_if.req_addr  = drv_addr[1];
    assign b_if.req_wdata = drv_wdata[1];
    assign b_if.rsp_ready = drv_rsp_ready[1];
    assign dut_ready      = {b_if.req_ready, a_if.req_ready};
    assign dut_rsp_valid  = {b_if.rsp_valid, a_if.rsp_valid};
    assign dut_rdata[0]   = a_if.rsp_rdata;
    assign dut_rdata[1]   = b_if.rsp_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the controller is doing at transaction level.
    logic [DATA_W-1:0] m_mem [16];
    req_t              m_op;
    bit                m_busy = 0, m_respond = 0, m_hs_now = 0;
    int                m_owner = 0, m_last = 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        if (port == 0) qa.push_back(r); else qb.push_back(r);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || drv_valid != 0 || m_busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(n >= budget), 0);
    endtask

    task automatic resetOnHandshake(input logic want_we, input int delay);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(m_hs_now && m_op.we == want_we) && n < 100);
        checkOutput("hs_timeout", 32'(n >= 100), 0);
        repeat (delay) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requesters: present queued commands, hold them until accepted.
    initial begin
        req_t r;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (hs_seen[p]) drv_valid[p] = 1'b0;
                if (!drv_valid[p] && $urandom_range(0, 99) < req_pct[p] &&
                    (p == 0 ? qa.size() : qb.size()) > 0) begin
                    if (p == 0) r = qa.pop_front(); else r = qb.pop_front();
                    drv_valid[p] = 1'b1;
                    drv_we[p]    = r.we;
                    drv_addr[p]  = r.addr;
                    drv_wdata[p] = r.wdata;
                end
                drv_rsp_ready[p] = ($urandom_range(0, 99) < rdy_pct[p]);
            end
        end
    end

    // Model: one accepted command at a time; a write occupies one issue cycle,
    // a read an issue cycle followed by a response held until its owner takes it.
    initial begin : monitor
        int g;
        forever begin
            @(negedge clk);
            m_hs_now = 0;
            hs_seen  = drv_valid & dut_ready;
            if (preload) for (int i = 0; i < 16; i++) m_mem[i] = 32'(i) * 32'h0101_0101;
            checkOutput("rd_wr_excl", 32'(rf_read_en & rf_write_en), 0);
            if (rst) begin
                checkOutput("rst_ready", 32'(dut_ready), 0);
                checkOutput("rst_rsp_valid", 32'(dut_rsp_valid), 0);
                checkOutput("rst_rd_en", 32'(rf_read_en), 0);
                checkOutput("rst_wr_en", 32'(rf_write_en), 0);
                checkOutput("rst_addr", 32'(rf_addr), 0);
                checkOutput("rst_wdata", rf_write_data, 0);
                m_busy = 0; m_respond = 0; m_last = 1;
            end else if (!m_busy) begin
                g = -1;
                if (drv_valid == 2'b11) g = 1 - m_last;
                else if (drv_valid[0])  g = 0;
                else if (drv_valid[1])  g = 1;
                checkOutput("a_ready", 32'(dut_ready[0]), 32'(g == 0));
                checkOutput("b_ready", 32'(dut_ready[1]), 32'(g == 1));
                checkOutput("idle_en", {30'd0, rf_read_en, rf_write_en}, 0);
                checkOutput("idle_rsp_valid", 32'(dut_rsp_valid), 0);
                if (g >= 0) begin
                    m_op.we = drv_we[g]; m_op.addr = drv_addr[g]; m_op.wdata = drv_wdata[g];
                    m_owner = g; m_last = g; m_busy = 1; m_respond = 0; m_hs_now = 1;
                end
            end else if (!m_respond) begin
                checkOutput("issue_wr_en", 32'(rf_write_en), 32'(m_op.we));
                checkOutput("issue_rd_en", 32'(rf_read_en), 32'(!m_op.we));
                checkOutput("issue_addr", 32'(rf_addr), 32'(m_op.addr));
                checkOutput("busy_ready", 32'(dut_ready), 0);
                checkOutput("issue_rsp_valid", 32'(dut_rsp_valid), 0);
                if (m_op.we) begin
                    checkOutput("issue_wdata", rf_write_data, m_op.wdata);
                    m_mem[m_op.addr] = m_op.wdata;
                    m_busy = 0;
                end else begin
                    m_respond = 1;
                end
            end else begin
                checkOutput("rsp_valid", 32'(dut_rsp_valid), 32'(m_owner == 0 ? 2'b01 : 2'b10));
                checkOutput("rsp_rdata", dut_rdata[m_owner], m_mem[m_op.addr]);
                checkOutput("rsp_ready_hold", 32'(dut_ready), 0);
                checkOutput("rsp_en", {30'd0, rf_read_en, rf_write_en}, 0);
                if (drv_rsp_ready[m_owner]) m_busy = 0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        preload = 1'b0;

        // Simultaneous reads straight after reset, then two more ties.
        applyStimulus(0, 0, 4'd1, '0);
        applyStimulus(1, 0, 4'd2, '0);
        applyStimulus(0, 0, 4'd2, '0);
        applyStimulus(1, 0, 4'd1, '0);
        waitIdle(60);

        applyStimulus(0, 1, 4'd3, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 4'd3, '0);
        waitIdle(30);

        // Owner stalls its response while B waits.
        rdy_pct[0] = 0;
        applyStimulus(0, 0, 4'd5, '0);
        repeat (2) @(posedge clk);
        applyStimulus(1, 0, 4'd6, '0);
        repeat (8) @(posedge clk);
        rdy_pct[0] = 100;
        waitIdle(30);

        for (int i = 0; i < 16; i++) applyStimulus(1, 1, 4'(i), 32'(i) * 32'h1111_1111);
        for (int i = 15; i >= 0; i--) applyStimulus(1, 0, 4'(i), '0);
        waitIdle(200);

        // Resets landing in the write, read and response cycles.
        applyStimulus(0, 1, 4'd7, 32'h1234_5678);
        waitIdle(20);
        applyStimulus(0, 1, 4'd7, 32'hCAFE_F00D);
        resetOnHandshake(1, 0);
        applyStimulus(0, 0, 4'd7, '0);
        waitIdle(20);
        applyStimulus(1, 0, 4'd9, '0);
        resetOnHandshake(0, 0);
        rdy_pct[1] = 0;
        applyStimulus(1, 0, 4'd10, '0);
        resetOnHandshake(0, 1);
        rdy_pct[1] = 100;
        applyStimulus(1, 0, 4'd11, '0);
        applyStimulus(0, 0, 4'd12, '0);
        waitIdle(40);

        // Random traffic with stalls and occasional resets.
        req_pct = '{50, 50};
        rdy_pct = '{60, 60};
        repeat (3000) begin
            @(posedge clk);
            #1;
            if (qa.size() < 2 && $urandom_range(0, 3) == 0)
                applyStimulus(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            if (qb.size() < 2 && $urandom_range(0, 3) == 0)
                applyStimulus(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        rdy_pct = '{100, 100};
        req_pct = '{100, 100};
        waitIdle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
